instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- ADDR_WIDTH, 32, PC and memory address width.
- INSTR_WIDTH, 32, instruction width.
- FIFO_DEPTH, 2, prefetch buffer entries (power of two, 2..8).
- RESET_PC, 0, first fetch address.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk_87, in, 1, sole clock.
- rst_n_87, in, 1, reset; asynchronous, active-low.
- imem_req_87, out, 1, fetch request valid.
- imem_addr_87, out, ADDR_WIDTH, fetch address.
- imem_gnt_87, in, 1, request accepted this cycle.
- imem_rvalid_87, in, 1, response valid; responses return in order, at least 1 cycle after grant.
- imem_rdata_87, in, INSTR_WIDTH, response instruction.
- stall_87, in, 1, decode stall; hold the IF/ID outputs.
- redirect_87, in, 1, branch/jump taken in decode (decode flush flag).
- redirect_pc_87, in, ADDR_WIDTH, new fetch address.
- halt_87, in, 1, system halt; stop fetching.
- instr_87, out, INSTR_WIDTH, IF/ID instruction; all-zero is a NOP.
- pc_87, out, ADDR_WIDTH, PC+4 of instr_87.
- halted_87, out, 1, fetch unit in HALTED state.

Function
REQ-003 The block SHALL hold a fetch PC (fpc), a FIFO of {instr, pc+4} pairs, an outstanding-request counter (outst), and a discard counter (disc).

REQ-004 The FSM SHALL have three states: RUN, DRAIN, HALTED.
- Reset goes to RUN.
- RUN goes to DRAIN when halt_87=1.
- DRAIN goes to HALTED when outst=0.
- HALTED is left only by reset.

REQ-005 imem_req_87 SHALL be 1 only in RUN, with redirect_87=0, when (FIFO count + outst) < FIFO_DEPTH. imem_addr_87 SHALL equal fpc.

REQ-006 On req&gnt, fpc SHALL increment by 4, wrapping modulo 2^ADDR_WIDTH, and outst SHALL increment.

REQ-007 On imem_rvalid_87:
- outst SHALL decrement.
- If disc>0, the response SHALL be dropped and disc decremented.
- Otherwise {rdata, address+4} SHALL be pushed into the FIFO.
- The FIFO SHALL never overflow; the limit in REQ-005 guarantees this.

REQ-008 redirect_87=1 SHALL, on the same clock edge:
- set fpc to redirect_pc_87;
- empty the FIFO;
- set disc to outst minus any response accepted that cycle;
- load the IF/ID outputs with instr_87=0 and pc_87=0.
Fetching from the new PC SHALL begin the following cycle.

REQ-009 IF/ID update priority SHALL be, per cycle:
- redirect: load NOP;
- else stall_87: hold instr_87 and pc_87 unchanged, no FIFO pop;
- else FIFO non-empty: pop head into instr_87/pc_87;
- else: load NOP (instr_87=0, pc_87=0).

REQ-010 A response arriving while the FIFO is empty and not stalled SHALL still pass through the FIFO. Minimum latency from rvalid to instr_87 SHALL be 1 cycle.

REQ-011 Simultaneous FIFO push and pop SHALL leave the count unchanged. Order SHALL be strictly preserved.

REQ-012 In DRAIN and HALTED, no new requests SHALL issue. Responses SHALL still be accepted and drained to IF/ID. Redirects SHALL be ignored in HALTED.

REQ-013 halted_87 SHALL be 1 only in HALTED.

Reset
REQ-014 While rst_n_87=0, asynchronously:
- fpc=RESET_PC; FIFO empty; outst=0; disc=0; state RUN;
- instr_87=0; pc_87=0; halted_87=0; imem_req_87=0.

REQ-015 Reset asserted mid-transaction SHALL abandon all in-flight requests. After release, the unit SHALL behave as if memory has no outstanding responses; the bench must not return stale rvalid after reset.

REQ-016 The first request SHALL issue in the first cycle after rst_n_87 rises.

Verification
REQ-017 Straight-line: memory with 1-cycle latency, gnt always 1, words 0x20010001, 0x20020002 at 0x0, 0x4 -> instr_87 shows 0x20010001/pc_87=0x4, then 0x20020002/pc_87=0x8 on consecutive cycles after the first fill.

REQ-018 Stall: stall_87 held 3 cycles with the FIFO full -> instr_87 and pc_87 unchanged, imem_req_87=0, no instruction lost or duplicated after release.

REQ-019 Redirect with 2 outstanding requests, redirect_pc_87=0x40 -> instr_87=0 the next cycle, both stale responses dropped, first non-NOP instr_87 is mem[0x40] with pc_87=0x44.

REQ-020 Simultaneous redirect and stall -> redirect wins, instr_87=0.

REQ-021 Halt: halt_87=1 with 1 outstanding request -> DRAIN, response delivered, halted_87=1 one cycle after outst reaches 0, no further imem_req_87.

REQ-022 Wrap: RESET_PC=0xFFFFFFFC -> second fetch address is 0x00000000, pc_87 for the first instruction is 0x00000000.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit. It issues in-order memory requests from a fetch PC
// and buffers the responses in a small prefetch FIFO that feeds the IF/ID
// register. A redirect flushes the buffer, and the responses still in flight
// from the old path are discarded as they arrive. Halt stops new requests and
// lets the outstanding responses drain before the unit parks in HALTED.
module instr_fetch #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    INSTR_WIDTH = 32,
   parameter int                    FIFO_DEPTH  = 2,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                   clk_87,
   input  logic                   rst_n_87,
   output logic                   imem_req_87,
   output logic [ADDR_WIDTH-1:0]  imem_addr_87,
   input  logic                   imem_gnt_87,
   input  logic                   imem_rvalid_87,
   input  logic [INSTR_WIDTH-1:0] imem_rdata_87,
   input  logic                   stall_87,
   input  logic                   redirect_87,
   input  logic [ADDR_WIDTH-1:0]  redirect_pc_87,
   input  logic                   halt_87,
   output logic [INSTR_WIDTH-1:0] instr_87,
   output logic [ADDR_WIDTH-1:0]  pc_87,
   output logic                   halted_87
);

   localparam int            PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int            CW      = PW + 1;
   localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

   state_t                 state;
   logic [ADDR_WIDTH-1:0]  fpc;
   logic [ADDR_WIDTH-1:0]  rpc;
   logic [CW-1:0]          fcount;
   logic [CW-1:0]          outst;
   logic [CW-1:0]          disc;
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [INSTR_WIDTH-1:0] fifo_instr [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0]  fifo_pc    [FIFO_DEPTH];

   logic                   redir;
   logic                   fire;
   logic                   push;
   logic                   pop;
   logic [CW:0]            occ;

   // Redirects are dead once halted; a granted request advances the fetch PC.
   // A response is buffered only if it belongs to the current path.
   assign redir = redirect_87 && (state != S_HALTED);
   assign occ   = {1'b0, fcount} + {1'b0, outst};
   assign fire  = imem_req_87 && imem_gnt_87;
   assign push  = imem_rvalid_87 && (disc == '0) && !redir;
   assign pop   = !redir && !stall_87 && (fcount != '0);

   // Requests only while running, never during a redirect, and only when every
   // in-flight response is guaranteed a FIFO slot.
   assign imem_req_87  = rst_n_87 && (state == S_RUN) && !redirect_87 && (occ < DEPTH_C);
   assign imem_addr_87 = fpc;

   // Fetch PC and the PC of the next response expected on the current path.
   always_ff @(posedge clk_87 or negedge rst_n_87) begin
      if (!rst_n_87) begin
         fpc <= RESET_PC;
         rpc <= RESET_PC;
      end else if (redir) begin
         fpc <= redirect_pc_87;
         rpc <= redirect_pc_87;
      end else begin
         if (fire) fpc <= fpc + ADDR_WIDTH'(4);
         if (push) rpc <= rpc + ADDR_WIDTH'(4);
      end
   end

   // Outstanding-request and discard counters; on a redirect everything still
   // in flight after this cycle's response becomes stale.
   always_ff @(posedge clk_87 or negedge rst_n_87) begin
      if (!rst_n_87) begin
         outst <= '0;
         disc  <= '0;
      end else begin
         outst <= outst + CW'(fire) - CW'(imem_rvalid_87);
         if (redir)
            disc <= outst - CW'(imem_rvalid_87);
         else if (imem_rvalid_87 && (disc != '0))
            disc <= disc - CW'(1);
      end
   end

   // Prefetch FIFO pointers and occupancy; a redirect empties it.
   always_ff @(posedge clk_87 or negedge rst_n_87) begin
      if (!rst_n_87) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fcount <= '0;
      end else if (redir) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fcount <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         fcount <= fcount + CW'(push) - CW'(pop);
      end
   end

   // FIFO storage: instruction paired with the PC+4 it was fetched from.
   always_ff @(posedge clk_87) begin
      if (push) begin
         fifo_instr[wr_ptr] <= imem_rdata_87;
         fifo_pc[wr_ptr]    <= rpc + ADDR_WIDTH'(4);
      end
   end

   // IF/ID register: redirect loads a NOP, stall holds, otherwise pop or NOP.
   always_ff @(posedge clk_87 or negedge rst_n_87) begin
      if (!rst_n_87) begin
         instr_87 <= '0;
         pc_87    <= '0;
      end else if (redir) begin
         instr_87 <= '0;
         pc_87    <= '0;
      end else if (!stall_87) begin
         if (pop) begin
            instr_87 <= fifo_instr[rd_ptr];
            pc_87    <= fifo_pc[rd_ptr];
         end else begin
            instr_87 <= '0;
            pc_87    <= '0;
         end
      end
   end

   // Run/drain/halted sequencing with a registered halted flag.
   always_ff @(posedge clk_87 or negedge rst_n_87) begin
      if (!rst_n_87) begin
         state     <= S_RUN;
         halted_87 <= 1'b0;
      end else begin
         case (state)
            S_RUN: begin
               if (halt_87) state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (outst == '0) begin
                  state     <= S_HALTED;
                  halted_87 <= 1'b1;
               end
            end
            default: begin
               state     <= S_HALTED;
               halted_87 <= 1'b1;
            end
         endcase
      end
   end

endmodule
